byte_mux_scanner: RTL and testbench

//  Upstream controller for the 8-input priority byte multiplexer (inputs A..H, select bits SAB,SC..SH).

---
 rtl/byte_mux_scanner_pkg.sv | 35 +++
 rtl/byte_mux_chan_next.sv | 31 +++
 rtl/byte_mux_scanner.sv | 172 +++++++++++++++++
 tb/tb_byte_mux_scanner.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_mux_scanner_pkg.sv
// byte_mux_scanner_pkg
//   Shared definitions for the byte mux scanner:
//   - state_t         : scanner FSM states
//   - CH_A .. CH_H    : channel indices for mux inputs A..H
//   - sel_encode()    : channel index -> 7-bit mux select {SH,SG,SF,SE,SD,SC,SAB}
package byte_mux_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [2:0] CH_A = 3'd0;
    localparam logic [2:0] CH_B = 3'd1;
    localparam logic [2:0] CH_C = 3'd2;
    localparam logic [2:0] CH_D = 3'd3;
    localparam logic [2:0] CH_E = 3'd4;
    localparam logic [2:0] CH_F = 3'd5;
    localparam logic [2:0] CH_G = 3'd6;
    localparam logic [2:0] CH_H = 3'd7;

    // Channel A is the mux default (no select asserted); channel k>=1 asserts
    // select bit k-1, so at most one select line is ever high.
    function automatic logic [6:0] sel_encode(input logic [2:0] ch);
        logic [6:0] sel;
        sel = '0;
        if (ch != CH_A) begin
            sel[ch - 3'd1] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/byte_mux_chan_next.sv
// byte_mux_chan_next
//   Combinational priority search over the channel mask.
//   Ports:
//     mask  [7:0] in  : channel enable mask (bit k = channel k)
//     cur   [2:0] in  : current channel
//     first       in  : 1 = return lowest set bit, 0 = lowest set bit strictly above cur
//     found       out : a qualifying channel exists
//     next  [2:0] out : the qualifying channel (CH_A when none)
module byte_mux_chan_next
    import byte_mux_scanner_pkg::*;
(
    input  logic [7:0] mask,
    input  logic [2:0] cur,
    input  logic       first,
    output logic       found,
    output logic [2:0] next
);

    // Walk from the top down so the last hit is the lowest qualifying bit.
    always_comb begin
        found = 1'b0;
        next  = CH_A;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                found = 1'b1;
                next  = 3'(i);
            end
        end
    end

endmodule

// File: rtl/byte_mux_scanner.sv
// byte_mux_scanner
//   Walks the enabled inputs of the 8-input byte mux in ascending order,
//   waits SettleCycles after each select change, captures the mux byte and
//   hands it to the consumer on a Valid_o/Ack_i handshake.
//   Parameters:
//     SettleCycles : cycles between select change and sampling Byte_i (0..15)
//     CntWidth     : settle counter width, must hold SettleCycles
//   Ports:
//     Clk_i, Reset_i (async, active high)
//     Enable_i     : low aborts any scan on the next edge (no Done_o)
//     Start_i      : start a scan, honoured only in IDLE
//     ChanMask_i   : channel mask, latched at scan start
//     Byte_i       : mux output byte
//     Sel_o        : mux selects {SH,SG,SF,SE,SD,SC,SAB}
//     Data_o/Chan_o: captured byte and its channel
//     Valid_o/Ack_i: output handshake
//     Busy_o       : scan in progress
//     Done_o       : one-cycle end-of-scan pulse
//   Build option: define BYTE_MUX_SCANNER_AUTORESTART_EN to re-latch
//   ChanMask_i and start a new scan straight out of DONE while enabled.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for Start_i
//   SETTLE   | select driven, counting down before sampling Byte_i
//   WAIT_ACK | Data_o/Chan_o presented with Valid_o, waiting for Ack_i
//   DONE     | scan finished, Done_o high for this cycle
module byte_mux_scanner
    import byte_mux_scanner_pkg::*;
#(
    parameter int SettleCycles = 1,
    parameter int CntWidth     = 4
) (
    input  logic       Clk_i,
    input  logic       Reset_i,
    input  logic       Enable_i,
    input  logic       Start_i,
    input  logic [7:0] ChanMask_i,
    input  logic [7:0] Byte_i,
    output logic [6:0] Sel_o,
    output logic [7:0] Data_o,
    output logic [2:0] Chan_o,
    output logic       Valid_o,
    input  logic       Ack_i,
    output logic       Busy_o,
    output logic       Done_o
);

    localparam logic [CntWidth-1:0] CNT_LOAD = CntWidth'(SettleCycles);
    localparam logic [CntWidth-1:0] CNT_ONE  = CntWidth'(1);

    state_t              state_q;
    logic [7:0]          mask_q;
    logic [CntWidth-1:0] cnt_q;
    logic [6:0]          sel_q;
    logic [7:0]          data_q;
    logic [2:0]          chan_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;

    logic                search_first;
    logic [7:0]          search_mask;
    logic                next_found;
    logic [2:0]          next_chan;

    // Scan starts (IDLE, and DONE when restarting) search the live input
    // mask; mid-scan advances search the latched copy above the current channel.
    assign search_first = (state_q == IDLE) || (state_q == DONE);
    assign search_mask  = search_first ? ChanMask_i : mask_q;

    byte_mux_chan_next u_chan_next (
        .mask  (search_mask),
        .cur   (chan_q),
        .first (search_first),
        .found (next_found),
        .next  (next_chan)
    );

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            chan_q  <= CH_A;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!Enable_i) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                sel_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (Start_i) begin
                            mask_q <= ChanMask_i;
                            if (!next_found) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                chan_q  <= next_chan;
                                sel_q   <= sel_encode(next_chan);
                                cnt_q   <= CNT_LOAD;
                                busy_q  <= 1'b1;
                                state_q <= SETTLE;
                            end
                        end
                    end
                    SETTLE: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end else begin
                            data_q  <= Byte_i;
                            valid_q <= 1'b1;
                            state_q <= WAIT_ACK;
                        end
                    end
                    WAIT_ACK: begin
                        if (Ack_i) begin
                            valid_q <= 1'b0;
                            if (next_found) begin
                                chan_q  <= next_chan;
                                sel_q   <= sel_encode(next_chan);
                                cnt_q   <= CNT_LOAD;
                                state_q <= SETTLE;
                            end else begin
                                sel_q   <= '0;
                                done_q  <= 1'b1;
                                state_q <= DONE;
`ifndef BYTE_MUX_SCANNER_AUTORESTART_EN
                                busy_q  <= 1'b0;
`endif
                            end
                        end
                    end
                    DONE: begin
`ifdef BYTE_MUX_SCANNER_AUTORESTART_EN
                        mask_q <= ChanMask_i;
                        if (next_found) begin
                            chan_q  <= next_chan;
                            sel_q   <= sel_encode(next_chan);
                            cnt_q   <= CNT_LOAD;
                            busy_q  <= 1'b1;
                            state_q <= SETTLE;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
`else
                        state_q <= IDLE;
`endif
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign Sel_o   = sel_q;
    assign Data_o  = data_q;
    assign Chan_o  = chan_q;
    assign Valid_o = valid_q;
    assign Busy_o  = busy_q;
    assign Done_o  = done_q;

endmodule

// File: tb/tb_byte_mux_scanner.sv
// tb_byte_mux_scanner
//   Scoreboard bench for byte_mux_scanner: expected {chan, sel, data} entries
//   are queued when a scan is started and popped as Valid_o beats appear.
//   Byte_i comes from a model of the mux that decodes Sel_o.
module tb_byte_mux_scanner;

    localparam int SETTLE = 1;
`ifdef BYTE_MUX_SCANNER_AUTORESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam logic [6:0] SEL_TAB [8] = '{7'h00, 7'h01, 7'h02, 7'h04,
                                           7'h08, 7'h10, 7'h20, 7'h40};

    typedef struct packed {
        logic [2:0] chan;
        logic [6:0] sel;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       start;
    logic [7:0] mask;
    logic [7:0] byte_in;
    logic [6:0] sel;
    logic [7:0] data;
    logic [2:0] chan;
    logic       valid;
    logic       ack;
    logic       busy;
    logic       done;

    logic       byte_force;
    logic [7:0] byte_forced;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    byte_mux_scanner #(.SettleCycles(SETTLE), .CntWidth(4)) dut (
        .Clk_i      (clk),
        .Reset_i    (rst),
        .Enable_i   (en),
        .Start_i    (start),
        .ChanMask_i (mask),
        .Byte_i     (byte_in),
        .Sel_o      (sel),
        .Data_o     (data),
        .Chan_o     (chan),
        .Valid_o    (valid),
        .Ack_i      (ack),
        .Busy_o     (busy),
        .Done_o     (done)
    );

    function automatic logic [2:0] sel_to_chan(input logic [6:0] s);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (s[i]) c = 3'(i + 1);
        end
        return c;
    endfunction

    assign byte_in = byte_force ? byte_forced : (8'h10 + {5'b0, sel_to_chan(sel)});

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_scan(input logic [7:0] m);
        for (int k = 0; k < 8; k++) begin
            if (m[k]) sb.push_back('{chan: 3'(k), sel: SEL_TAB[k], data: 8'(8'h10 + k)});
        end
    endtask

    // Returns at the negedge right after the start edge; mask input is then
    // scrambled to show the scanner works from its latched copy.
    task automatic start_scan(input logic [7:0] m, input logic [7:0] m_after);
        @(negedge clk);
        mask  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mask  = m_after;
    endtask

    task automatic check_beat(input string pfx);
        exp_t e;
        if (sb.size() == 0) begin
            check({pfx, "_unexpected_valid_chan"}, 32'(chan), 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            check({pfx, "_chan"}, 32'(chan), 32'(e.chan));
            check({pfx, "_data"}, 32'(data), 32'(e.data));
            check({pfx, "_sel"},  32'(sel),  32'(e.sel));
            check({pfx, "_busy"}, 32'(busy), 32'd1);
        end
    endtask

    // Acks every beat immediately; checks settle latency and the Done_o pulse.
    task automatic service(input string pfx, input bit busy_at_done);
        int gap;
        bit seen_done;
        gap = 0;
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
            if (done) begin
                seen_done = 1'b1;
                check({pfx, "_done_busy"},  32'(busy),      32'(busy_at_done));
                check({pfx, "_done_sel"},   32'(sel),       32'd0);
                check({pfx, "_done_valid"}, 32'(valid),     32'd0);
                check({pfx, "_sb_empty"},   32'(sb.size()), 32'd0);
            end else if (valid) begin
                check({pfx, "_latency"}, 32'(gap), 32'(SETTLE + 1));
                check_beat(pfx);
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
                gap = 0;
            end else begin
                @(negedge clk);
                gap++;
            end
        end
        check({pfx, "_done_seen"}, 32'(seen_done), 32'd1);
        @(negedge clk);
        check({pfx, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (valid) seen = 1'b1;
            else @(negedge clk);
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b1;
        start       = 1'b0;
        ack         = 1'b0;
        mask        = 8'h00;
        byte_force  = 1'b0;
        byte_forced = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_sel",   32'(sel),   32'd0);
        check("rst_data",  32'(data),  32'd0);
        check("rst_chan",  32'(chan),  32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // full mask
        push_scan(8'hFF);
        start_scan(8'hFF, 8'h00);
        check("full_busy_at_start", 32'(busy), 32'd1);
        check("full_sel_at_start",  32'(sel),  32'd0);
        service("full", AUTO);

        // sparse mask
        push_scan(8'hA4);
        start_scan(8'hA4, 8'h01);
        check("sparse_sel_at_start", 32'(sel), 32'h02);
        service("sparse", AUTO);

        // empty mask: Done_o right after the start edge, never busy
        start_scan(8'h00, 8'h00);
        check("mask0_valid", 32'(valid), 32'd0);
        service("mask0", 1'b0);
        check("mask0_busy_after", 32'(busy), 32'd0);

        // backpressure: hold Ack low while the mux byte keeps changing
        push_scan(8'h0C);
        start_scan(8'h0C, 8'h00);
        wait_valid("bp_first_valid");
        check_beat("bp_first");
        byte_force = 1'b1;
        for (int i = 0; i < 20; i++) begin
            byte_forced = 8'(8'hA0 + i);
            @(negedge clk);
            check("bp_valid", 32'(valid), 32'd1);
            check("bp_data",  32'(data),  32'h12);
            check("bp_chan",  32'(chan),  32'd2);
            check("bp_sel",   32'(sel),   32'h02);
        end
        byte_force = 1'b0;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        service("bp", AUTO);

        // abort via Enable_i while waiting for the ack of channel 3
        push_scan(8'h18);
        start_scan(8'h18, 8'h00);
        wait_valid("abort_valid");
        check_beat("abort_ch3");
        en = 1'b0;
        @(negedge clk);
        check("abort_valid_low", 32'(valid), 32'd0);
        check("abort_sel",       32'(sel),   32'd0);
        check("abort_busy",      32'(busy),  32'd0);
        check("abort_chan_kept", 32'(chan),  32'd3);
        check("abort_data_kept", 32'(data),  32'h13);
        for (int i = 0; i < 5; i++) begin
            check("abort_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        sb.delete();
        en = 1'b1;

        // async reset during SETTLE
        start_scan(8'h02, 8'h00);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        check("rstmid_sel_before",  32'(sel),  32'h01);
        #1 rst = 1'b1;
        #1;
        check("rstmid_sel",   32'(sel),   32'd0);
        check("rstmid_chan",  32'(chan),  32'd0);
        check("rstmid_data",  32'(data),  32'd0);
        check("rstmid_busy",  32'(busy),  32'd0);
        check("rstmid_valid", 32'(valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rstmid_idle_valid", 32'(valid), 32'd0);
            check("rstmid_idle_done",  32'(done),  32'd0);
        end

        // mask 8'h81 left on the input after the scan
        push_scan(8'h81);
        start_scan(8'h81, 8'h81);
        service("m81", AUTO);
`ifdef BYTE_MUX_SCANNER_AUTORESTART_EN
        sb.push_back('{chan: 3'd0, sel: 7'h00, data: 8'h10});
        wait_valid("auto_restart_valid");
        check_beat("auto_restart");
        en = 1'b0;
        @(negedge clk);
        sb.delete();
        en = 1'b1;
`else
        for (int i = 0; i < 10; i++) begin
            check("norestart_valid", 32'(valid), 32'd0);
            check("norestart_busy",  32'(busy),  32'd0);
            @(negedge clk);
        end
`endif
        mask = 8'h00;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
